// File: rtl/fifo_word_packer.sv
// Packs pairs of words from a one-cycle-latency FIFO into {hi, lo} output words.
// Define FIFO_PACK_PARITY_EN to add the registered out_parity output.
module fifo_word_packer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_data_out,
  output logic                    fifo_read,
  input  logic                    flush,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef FIFO_PACK_PARITY_EN
  output logic                    out_parity,
`endif
  output logic [CNT_WIDTH-1:0]    out_count
);

  typedef enum logic [2:0] {
    StRdLo,
    StCapLo,
    StRdHi,
    StCapHi,
    StOut
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  valid_q;
`ifdef FIFO_PACK_PARITY_EN
  logic                  parity_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRdLo;
      lo_q     <= '0;
      hi_q     <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
`ifdef FIFO_PACK_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StRdLo: begin
          if (!fifo_empty) state_q <= StCapLo;
        end
        StCapLo: begin
          lo_q    <= fifo_data_out;
          state_q <= StRdHi;
        end
        StRdHi: begin
          // A non-empty FIFO wins over flush.
          if (!fifo_empty) begin
            state_q <= StCapHi;
          end else if (flush) begin
            hi_q     <= '0;
            valid_q  <= 1'b1;
            state_q  <= StOut;
`ifdef FIFO_PACK_PARITY_EN
            parity_q <= ^lo_q;
`endif
          end
        end
        StCapHi: begin
          hi_q     <= fifo_data_out;
          valid_q  <= 1'b1;
          state_q  <= StOut;
`ifdef FIFO_PACK_PARITY_EN
          parity_q <= ^{fifo_data_out, lo_q};
`endif
        end
        StOut: begin
          if (out_ready) begin
            count_q <= count_q + 1'b1;
            valid_q <= 1'b0;
            state_q <= StRdLo;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= StRdLo;
        end
      endcase
    end
  end

  // Read request is combinational so it can never lead fifo_empty; gated by rst
  // because the reset state itself is a read state.
  assign fifo_read = !rst && !fifo_empty && ((state_q == StRdLo) || (state_q == StRdHi));
  assign out_data  = {hi_q, lo_q};
  assign out_valid = valid_q;
  assign out_count = count_q;
`ifdef FIFO_PACK_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer with a one-cycle-latency FIFO model.
// Build with FIFO_PACK_PARITY_EN defined to also check out_parity.
module tb_fifo_word_packer;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_read;
  logic          flush = 1'b0;
  logic [2*DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_count;
`ifdef FIFO_PACK_PARITY_EN
  logic          out_parity;
`endif

  fifo_word_packer #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_read    (fifo_read),
    .flush        (flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef FIFO_PACK_PARITY_EN
    .out_parity   (out_parity),
`endif
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  int unsigned     checks = 0;
  int unsigned     failures = 0;
  logic [DW-1:0]   fifo_q[$];
  logic [2*DW-1:0] sb_q[$];
  logic [CW-1:0]   exp_count = '0;
  logic            hold_prev = 1'b0;
  logic [2*DW-1:0] data_prev = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model: data appears the cycle after a read.
  always @(posedge clk) begin
    if (fifo_read && fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic push_pair(input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    push_word(lo);
    push_word(hi);
    sb_q.push_back({hi, lo});
  endtask

  // Monitor sampled mid-cycle, after stimulus changes at the falling edge settle.
  always @(negedge clk) begin
    logic [2*DW-1:0] exp;
    #2;
    if (!rst) begin
      if (fifo_read) check_eq("rd_while_empty", {63'b0, fifo_empty}, 64'd0);
      if (hold_prev) begin
        check_eq("hold_valid", {63'b0, out_valid}, 64'd1);
        check_eq("hold_data", {32'b0, out_data}, {32'b0, data_prev});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_word", {32'b0, out_data}, 64'hdead_0000_0000_0000);
        end else begin
          exp = sb_q.pop_front();
          check_eq("data", {32'b0, out_data}, {32'b0, exp});
          check_eq("count", {60'b0, out_count}, {60'b0, exp_count});
`ifdef FIFO_PACK_PARITY_EN
          check_eq("parity", {63'b0, out_parity}, {63'b0, ^exp});
`endif
          exp_count = exp_count + 1'b1;
        end
      end
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic wait_valid(input int unsigned budget);
    int unsigned n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check_eq("valid_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain(input int unsigned budget, input bit rand_ready);
    int unsigned n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    if (sb_q.size() != 0 || out_valid) begin
      check_eq("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state, with data already waiting in the FIFO.
    @(negedge clk);
    push_pair(16'd435, 16'd90);
    #1;
    check_eq("rst_read", {63'b0, fifo_read}, 64'd0);
    check_eq("rst_valid", {63'b0, out_valid}, 64'd0);
    check_eq("rst_data", {32'b0, out_data}, 64'd0);
    check_eq("rst_count", {60'b0, out_count}, 64'd0);

    // Basic pack and latency: read at cycle N, valid at N+4 for one cycle.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("lat_read", {63'b0, fifo_read}, 64'd1);
    repeat (3) @(negedge clk);
    #1 check_eq("lat_early", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    #1 check_eq("lat_valid", {63'b0, out_valid}, 64'd1);
    check_eq("basic_data", {32'b0, out_data}, {32'b0, 16'd90, 16'd435});
    @(negedge clk);
    #1 check_eq("valid_1cyc", {63'b0, out_valid}, 64'd0);
    check_eq("basic_count", {60'b0, out_count}, 64'd1);

    // Backpressure with more data queued behind the held word.
    out_ready = 1'b0;
    push_pair(16'd7, 16'd8);
    wait_valid(20);
    push_pair(16'd1, 16'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_eq("bp_data", {32'b0, out_data}, {32'b0, 16'd8, 16'd7});
      check_eq("bp_read", {63'b0, fifo_read}, 64'd0);
      check_eq("bp_count", {60'b0, out_count}, 64'd1);
    end
    out_ready = 1'b1;
    wait_drain(40, 1'b0);
    check_eq("bp_count_after", {60'b0, out_count}, 64'd3);

    // Empty hold with flush asserted: flush is ignored in RD_LO.
    flush = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check_eq("empty_read", {63'b0, fifo_read}, 64'd0);
      check_eq("empty_valid", {63'b0, out_valid}, 64'd0);
    end
    push_word(16'd45);
    sb_q.push_back({16'd0, 16'd45});
    wait_drain(40, 1'b0);
    // Flush held high while data is available: FIFO takes priority.
    push_pair(16'd3, 16'd4);
    wait_drain(40, 1'b0);
    flush = 1'b0;
    check_eq("flush_count", {60'b0, out_count}, 64'd5);

    // Mid-operation reset in CAP_HI discards the captured half-word.
    push_word(16'd11);
    push_word(16'd22);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mrst_data", {32'b0, out_data}, 64'd0);
    check_eq("mrst_valid", {63'b0, out_valid}, 64'd0);
    check_eq("mrst_read", {63'b0, fifo_read}, 64'd0);
    check_eq("mrst_count", {60'b0, out_count}, 64'd0);
    @(negedge clk);
    fifo_q.delete();
    exp_count = '0;
    rst = 1'b0;
    push_pair(16'd5, 16'd4435);
    wait_drain(40, 1'b0);

    // Counter wrap: 17 words since reset with random backpressure.
    for (int i = 0; i < 16; i++) push_pair(16'($urandom), 16'($urandom));
    wait_drain(1000, 1'b1);
    check_eq("wrap_count", {60'b0, out_count}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
